// File: rtl/getin_uart_rx.sv
// UART receiver assembling byte pairs (high byte first) into the 16-bit getin word.
// Define GETIN_UART_PARITY_EN for 8E1 frames with a live parity_error; otherwise 8N1.
module getin_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] getin,
    output logic        word_valid,
    output logic        framing_error,
    output logic        parity_error,
    output logic        byte_phase
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   getin_q, getin_d;
    logic          word_valid_q, word_valid_d;
    logic          framing_error_q, framing_error_d;
    logic          parity_error_q, parity_error_d;
    logic          byte_phase_q, byte_phase_d;
    logic          par_bad;

`ifdef GETIN_UART_PARITY_EN
    logic par_q, par_d;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + 1'b1;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        hi_d            = hi_q;
        getin_d         = getin_q;
        word_valid_d    = 1'b0;
        framing_error_d = 1'b0;
        parity_error_d  = 1'b0;
        byte_phase_d    = byte_phase_q;
`ifdef GETIN_UART_PARITY_EN
        par_d           = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Falling edge only, so a held break does not retrigger.
                if (rx_prev_q && !rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef GETIN_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef GETIN_UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d           = '0;
                    state_d         = S_IDLE;
                    framing_error_d = !rx_s_q;
                    parity_error_d  = par_bad;
                    if (!rx_s_q || par_bad) begin
                        byte_phase_d = 1'b0;
                    end else if (!byte_phase_q) begin
                        hi_d         = shift_q;
                        byte_phase_d = 1'b1;
                    end else begin
                        getin_d      = {hi_q, shift_q};
                        word_valid_d = 1'b1;
                        byte_phase_d = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_prev_q       <= 1'b1;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            hi_q            <= '0;
            getin_q         <= '0;
            word_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            byte_phase_q    <= 1'b0;
`ifdef GETIN_UART_PARITY_EN
            par_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx;
            rx_s_q          <= rx_meta_q;
            rx_prev_q       <= rx_s_q;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            hi_q            <= hi_d;
            getin_q         <= getin_d;
            word_valid_q    <= word_valid_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            byte_phase_q    <= byte_phase_d;
`ifdef GETIN_UART_PARITY_EN
            par_q           <= par_d;
`endif
        end
    end

    assign getin         = getin_q;
    assign word_valid    = word_valid_q;
    assign framing_error = framing_error_q;
    assign parity_error  = parity_error_q;
    assign byte_phase    = byte_phase_q;
endmodule
